titan_mem_lsu: RTL and testbench
================================

// Module: titan_mem_lsu
// PURPOSE
//  MEM-stage load/store unit; consumes the EX/MEM register outputs (mem_result as address, mem_store_data, mem_mem_flags).
//  Acts as data-bus initiator: aligns and issues one Wishbone-style access per instruction, then returns extended load data.
//  Stalls the pipeline until the access completes; flags misaligned and faulting accesses to the exception unit.
// PARAMETERS
//  (none)
// PORTS
//  clk               in   1   clock, all state on rising edge
//  rst               in   1   asynchronous, active-low reset
//  mem_address       in   32  effective address (EX/MEM mem_result)
//  mem_store_data    in   32  raw store data, right-justified
//  mem_mem_flags     in   6   [0] read [1] write [2] byte [3] half [4] word [5] signed load
//  hold_in           in   1   stall from other sources; instruction stays in MEM
//  kill              in   1   instruction in MEM is being squashed
//  dport_address     out  32  word-aligned bus address {addr[31:2],2'b00}
//  dport_data_o      out  32  lane-replicated store data
//  dport_sel         out  4   byte-lane enables
//  dport_we          out  1   write strobe
//  dport_cyc         out  1   bus cycle active
//  dport_stb         out  1   strobe (equals dport_cyc)
//  dport_data_i      in   32  read data, valid with ack
//  dport_ack         in   1   access done
//  dport_err         in   1   access faulted (exclusive with ack)
//  lsu_stall         out  1   stall request to pipeline control
//  mem_load_data     out  32  aligned, extended load result
//  ld_misaligned     out  1   load address misaligned (comb)
//  st_misaligned     out  1   store address misaligned (comb)
//  ld_access_fault   out  1   load bus error (registered)
//  st_access_fault   out  1   store bus error (registered)
// BEHAVIOUR
//  Reset: state IDLE; all dport_* outputs 0; mem_load_data 0; both fault flags 0.
//  req = read|write. mis = (half & addr[0]) | (word & |addr[1:0]). Misaligned flags = mis & read / mis & write, comb.
//  sel: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111. Data: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
//  Load: shift dport_data_i right by 8*addr[1:0]; take [7:0]/[15:0]/[31:0]; sign-extend if flags[5], else zero-extend.
//  FSM IDLE:
//    req & !mis & !kill -> BUSY at next edge; dport_* registered from inputs at that edge.
//    Otherwise stay.
//  FSM BUSY:
//    Bus outputs held constant.
//    On ack or err: drop cyc/stb/we; capture load data on ack; set matching fault flag on err.
//    Then -> DONE, or -> IDLE if kill was seen at any point during BUSY (result and fault discarded).
//  FSM DONE:
//    mem_load_data and fault flags held.
//    hold_in=1 -> stay (no reissue). hold_in=0 or kill -> IDLE; fault flags cleared on leaving.
//  lsu_stall = (IDLE & req & !mis & !kill) | BUSY. Deasserted in DONE.
//    Minimum access latency: 2 cycles of stall (issue + ack cycle) with zero-wait ack.
//  kill never aborts an open bus cycle; cyc stays high until ack/err.
//  Reset asserted mid-access drops cyc/stb immediately (asynchronous).
//  Flag encodings with both read and write, or no size bit, are not issued (treated as req=0).
// TESTING
//  Aligned word load:
//    flags=0x11, addr=0x100, ack 1 cycle after cyc, data_i=0xDEADBEEF
//    -> sel=4'hF, stall 2 cycles, mem_load_data=0xDEADBEEF.
//  Signed byte load:
//    flags=0x25, addr=0x103, data_i=0x80123456 -> sel=4'b1000, mem_load_data=0xFFFFFF80.
//    Same access with flags[5]=0 -> 0x00000080.
//  Half store:
//    flags=0x0A, addr=0x202, data=0x0000ABCD -> we=1, sel=4'b1100, data_o=0xABCDABCD.
//  Misaligned word store:
//    addr=0x301 -> st_misaligned=1 same cycle, dport_cyc never rises, lsu_stall=0.
//  Bus error on load with 3 wait states -> stall 5 cycles, ld_access_fault=1 in DONE.
//    hold_in=1 for 2 more cycles -> no second cyc.
//  kill during BUSY -> cyc held until ack, then IDLE, no fault and no stall afterward.
//    rst low mid-BUSY -> all dport_* 0 immediately.

Source files
------------

// File: rtl/titan_mem_lsu.sv
// titan_mem_lsu: MEM-stage load/store unit driving a Wishbone-style data port
// Ports: clk, rst (async active-low); mem_address/mem_store_data/mem_mem_flags from EX/MEM;
// hold_in/kill from pipeline control; dport_* bus initiator signals; lsu_stall to control;
// mem_load_data aligned/extended load result; ld/st_misaligned (comb), ld/st_access_fault (registered).
module titan_mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_store_data,
  input  logic [5:0]  mem_mem_flags,
  input  logic        hold_in,
  input  logic        kill,
  output logic [31:0] dport_address,
  output logic [31:0] dport_data_o,
  output logic [3:0]  dport_sel,
  output logic        dport_we,
  output logic        dport_cyc,
  output logic        dport_stb,
  input  logic [31:0] dport_data_i,
  input  logic        dport_ack,
  input  logic        dport_err,
  output logic        lsu_stall,
  output logic [31:0] mem_load_data,
  output logic        ld_misaligned,
  output logic        st_misaligned,
  output logic        ld_access_fault,
  output logic        st_access_fault
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0]  state, off_q, size_q;
  logic        rd_q, sgn_q, killed, req, mis, go, drop;
  logic [3:0]  sel;
  logic [31:0] wdata, sh, ld;
  // Only one direction and exactly one size form a real access.
  always_comb begin
    req   = (mem_mem_flags[0] ^ mem_mem_flags[1]) & $onehot(mem_mem_flags[4:2]);
    mis   = (mem_mem_flags[3] & mem_address[0]) | (mem_mem_flags[4] & |mem_address[1:0]);
    go    = (state == IDLE) & req & !mis & !kill;
    sel   = mem_mem_flags[2] ? 4'b0001 << mem_address[1:0] :
            mem_mem_flags[3] ? 4'b0011 << mem_address[1:0] : 4'b1111;
    wdata = mem_mem_flags[2] ? {4{mem_store_data[7:0]}} :
            mem_mem_flags[3] ? {2{mem_store_data[15:0]}} : mem_store_data;
    sh    = dport_data_i >> {off_q, 3'b000};
    ld    = size_q[0] ? {{24{sgn_q & sh[7]}}, sh[7:0]} :
            size_q[1] ? {{16{sgn_q & sh[15]}}, sh[15:0]} : sh;
    drop  = killed | kill;
  end
  assign ld_misaligned = mis & mem_mem_flags[0];
  assign st_misaligned = mis & mem_mem_flags[1];
  assign lsu_stall     = go | (state == BUSY);
  assign dport_stb     = dport_cyc;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      dport_address   <= '0;
      dport_data_o    <= '0;
      dport_sel       <= '0;
      dport_we        <= 1'b0;
      dport_cyc       <= 1'b0;
      mem_load_data   <= '0;
      ld_access_fault <= 1'b0;
      st_access_fault <= 1'b0;
      rd_q            <= 1'b0;
      sgn_q           <= 1'b0;
      off_q           <= '0;
      size_q          <= '0;
      killed          <= 1'b0;
    end else if (go) begin
      state         <= BUSY;
      dport_address <= {mem_address[31:2], 2'b00};
      dport_data_o  <= wdata;
      dport_sel     <= sel;
      dport_we      <= mem_mem_flags[1];
      dport_cyc     <= 1'b1;
      rd_q          <= mem_mem_flags[0];
      sgn_q         <= mem_mem_flags[5];
      off_q         <= mem_address[1:0];
      size_q        <= mem_mem_flags[3:2];
      killed        <= 1'b0;
    end else if (state == BUSY) begin
      // A squash never aborts the bus cycle; it is remembered and applied at completion.
      killed <= drop;
      if (dport_ack | dport_err) begin
        dport_cyc <= 1'b0;
        dport_we  <= 1'b0;
        state     <= drop ? IDLE : DONE;
        if (!drop) begin
          if (dport_ack & rd_q) mem_load_data <= ld;
          ld_access_fault <= dport_err & rd_q;
          st_access_fault <= dport_err & !rd_q;
        end
      end
    end else if (state == DONE && (kill || !hold_in)) begin
      state           <= IDLE;
      ld_access_fault <= 1'b0;
      st_access_fault <= 1'b0;
    end
  end
endmodule

// File: tb/tb_titan_mem_lsu.sv
// tb_titan_mem_lsu: randomized scoreboard bench for titan_mem_lsu
module tb_titan_mem_lsu;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] mem_address = '0, mem_store_data = '0, dport_data_i = '0;
  logic [5:0] mem_mem_flags = '0;
  logic hold_in = 1'b0, kill = 1'b0, dport_ack = 1'b0, dport_err = 1'b0;
  logic [31:0] dport_address, dport_data_o, mem_load_data;
  logic [3:0] dport_sel;
  logic dport_we, dport_cyc, dport_stb, lsu_stall;
  logic ld_misaligned, st_misaligned, ld_access_fault, st_access_fault;
  titan_mem_lsu dut (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_store_data(mem_store_data),
    .mem_mem_flags(mem_mem_flags), .hold_in(hold_in), .kill(kill),
    .dport_address(dport_address), .dport_data_o(dport_data_o), .dport_sel(dport_sel),
    .dport_we(dport_we), .dport_cyc(dport_cyc), .dport_stb(dport_stb),
    .dport_data_i(dport_data_i), .dport_ack(dport_ack), .dport_err(dport_err),
    .lsu_stall(lsu_stall), .mem_load_data(mem_load_data),
    .ld_misaligned(ld_misaligned), .st_misaligned(st_misaligned),
    .ld_access_fault(ld_access_fault), .st_access_fault(st_access_fault)
  );
  always #5 clk = ~clk;
  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] s; logic we; } bus_t;
  typedef struct { logic [31:0] ld; logic lf; logic sf; } res_t;
  bus_t bq[$];
  res_t rq[$];
  bus_t cur;
  res_t r;
  int total = 0, bad = 0;
  int s_waits = 0;
  bit s_err = 0;
  logic [31:0] s_rdata = '0, last_ld = '0;
  logic prev_cyc = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [3:0] msel(input logic [5:0] f, input logic [1:0] off);
    if (f[2]) return 4'd1 << off;
    if (f[3]) return 4'd3 << off;
    return 4'hF;
  endfunction
  function automatic logic [31:0] rep(input logic [5:0] f, input logic [31:0] d);
    if (f[2]) return (d & 32'hFF) * 32'h01010101;
    if (f[3]) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction
  function automatic logic [31:0] ext(input logic [5:0] f, input logic [1:0] off, input logic [31:0] d);
    logic [31:0] v;
    v = d >> (8 * off);
    if (f[2]) begin
      v = v & 32'hFF;
      return (f[5] && v >= 32'h80) ? v + 32'hFFFFFF00 : v;
    end
    if (f[3]) begin
      v = v & 32'hFFFF;
      return (f[5] && v >= 32'h8000) ? v + 32'hFFFF0000 : v;
    end
    return v;
  endfunction
  // Bus slave: responds after s_waits idle cycles with one ack/err pulse.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (dport_ack || dport_err || !dport_cyc) begin
        dport_ack = 0; dport_err = 0; cnt = 0;
      end else if (cnt == s_waits) begin
        if (s_err) dport_err = 1;
        else begin dport_ack = 1; dport_data_i = s_rdata; end
      end else cnt++;
    end
  end
  // Monitor: pops bus and result expectations as the DUT presents them.
  always @(negedge clk) begin
    if (rst) begin
      if (dport_cyc && !prev_cyc) begin
        if (bq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_cyc: got addr %h want no access", dport_address);
        end else cur = bq.pop_front();
      end
      if (dport_cyc) begin
        chk("bus_addr", dport_address, cur.a);
        chk("bus_sel", {28'd0, dport_sel}, {28'd0, cur.s});
        chk("bus_data", dport_data_o, cur.d);
        chk("bus_we", {31'd0, dport_we}, {31'd0, cur.we});
        chk("bus_stb", {31'd0, dport_stb}, 32'd1);
      end
      if (!dport_cyc && prev_cyc) begin
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got completion want none");
        end else begin
          r = rq.pop_front();
          chk("load_data", mem_load_data, r.ld);
          chk("ld_fault", {31'd0, ld_access_fault}, {31'd0, r.lf});
          chk("st_fault", {31'd0, st_access_fault}, {31'd0, r.sf});
        end
      end
    end
    prev_cyc = dport_cyc;
  end
  task automatic access(input logic [5:0] f, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input int waits, input bit e, input int holds, input bit kl);
    bit legal, mis, go, lf, sf;
    int n;
    bus_t b;
    res_t x;
    legal = (f[0] ^ f[1]) && ($countones(f[4:2]) == 1);
    mis = (f[3] && a[0]) || (f[4] && a[1:0] != 2'b00);
    go = legal && !mis;
    lf = go && e && f[0] && !kl;
    sf = go && e && f[1] && !kl;
    s_waits = waits; s_err = e; s_rdata = rd;
    mem_address = a; mem_store_data = d; mem_mem_flags = f; hold_in = (holds > 0); kill = 0;
    if (go) begin
      b.a = a & 32'hFFFFFFFC; b.d = rep(f, d); b.s = msel(f, a[1:0]); b.we = f[1];
      bq.push_back(b);
      if (!kl && !e && f[0]) last_ld = ext(f, a[1:0], rd);
      x.ld = last_ld; x.lf = lf; x.sf = sf;
      rq.push_back(x);
    end
    #1;
    chk("ld_misaligned", {31'd0, ld_misaligned}, {31'd0, mis && f[0]});
    chk("st_misaligned", {31'd0, st_misaligned}, {31'd0, mis && f[1]});
    n = 0;
    forever begin
      @(negedge clk);
      if (!lsu_stall) break;
      n++;
      if (n > 40) begin
        total++; bad++;
        $display("FAIL stall_timeout: got >40 stall cycles want %0d", waits + 2);
        break;
      end
      @(posedge clk); #1;
      if (kl && go) kill = 1;
    end
    chk("stall_cycles", n, go ? waits + 2 : 0);
    chk("done_ld_fault", {31'd0, ld_access_fault}, {31'd0, lf});
    chk("done_st_fault", {31'd0, st_access_fault}, {31'd0, sf});
    repeat (holds) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_ld_fault", {31'd0, ld_access_fault}, {31'd0, lf});
      chk("hold_no_reissue", {31'd0, dport_cyc}, 32'd0);
    end
    @(posedge clk); #1;
    mem_mem_flags = 0; hold_in = 0; kill = 0;
    @(posedge clk); #1;
    chk("fault_cleared", {30'd0, ld_access_fault, st_access_fault}, 32'd0);
    chk("idle_no_stall", {31'd0, lsu_stall}, 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [5:0] f;
    logic [2:0] szb;
    logic [31:0] a;
    int k;
    @(negedge clk);
    chk("rst_cyc", {31'd0, dport_cyc}, 32'd0);
    chk("rst_bus", dport_address | dport_data_o | {28'd0, dport_sel}, 32'd0);
    chk("rst_we_stb", {30'd0, dport_we, dport_stb}, 32'd0);
    chk("rst_load", mem_load_data, 32'd0);
    chk("rst_faults", {30'd0, ld_access_fault, st_access_fault}, 32'd0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    access(6'h11, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0);
    access(6'h25, 32'h103, 32'h0, 32'h80123456, 0, 0, 0, 0);
    access(6'h05, 32'h103, 32'h0, 32'h80123456, 1, 0, 0, 0);
    access(6'h0A, 32'h202, 32'h0000ABCD, 32'h0, 0, 0, 1, 0);
    access(6'h12, 32'h301, 32'h11223344, 32'h0, 0, 0, 1, 0);
    access(6'h29, 32'h101, 32'h0, 32'h0, 0, 0, 0, 0);
    access(6'h11, 32'h400, 32'h0, 32'h55AA55AA, 3, 1, 2, 0);
    access(6'h12, 32'h404, 32'hCAFEF00D, 32'h0, 1, 1, 0, 0);
    access(6'h11, 32'h500, 32'h0, 32'h12345678, 2, 0, 0, 1);
    access(6'h11, 32'h504, 32'h0, 32'h0BADF00D, 0, 1, 1, 1);
    access(6'h13, 32'h600, 32'h0, 32'h0, 0, 0, 0, 0);
    access(6'h01, 32'h600, 32'h0, 32'h0, 0, 0, 0, 0);
    access(6'h2D, 32'h700, 32'h0, 32'h0, 0, 0, 0, 0);
    for (k = 0; k < 80; k++) begin
      szb = 3'd1 << $urandom_range(0, 2);
      f = {1'($urandom_range(0, 1)), szb, $urandom_range(0, 1) ? 2'b10 : 2'b01};
      case ($urandom_range(0, 15))
        0: f[4:2] = 3'b000;
        1: f[1:0] = 2'b11;
        default: ;
      endcase
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = szb[2] ? a & 32'hFFFFFFFC : szb[1] ? a & 32'hFFFFFFFE : a;
      access(f, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 7) == 0,
             $urandom_range(0, 2), $urandom_range(0, 7) == 0);
    end
    s_waits = 10; s_err = 0;
    mem_address = 32'h800; mem_store_data = 32'h1234; mem_mem_flags = 6'h12;
    cur.a = 32'h800; cur.d = 32'h1234; cur.s = 4'hF; cur.we = 1;
    bq.push_back(cur);
    @(posedge clk); #1;
    mem_mem_flags = 0;
    @(posedge clk); #1;
    chk("busy_cyc", {31'd0, dport_cyc}, 32'd1);
    rst = 0;
    #1;
    chk("areset_cyc_stb", {30'd0, dport_cyc, dport_stb}, 32'd0);
    chk("areset_we", {31'd0, dport_we}, 32'd0);
    chk("areset_bus", dport_address | dport_data_o | {28'd0, dport_sel}, 32'd0);
    chk("areset_stall", {31'd0, lsu_stall}, 32'd0);
    last_ld = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    access(6'h09, 32'h902, 32'h0, 32'h8001_7FFF, 0, 0, 0, 0);
    access(6'h29, 32'h902, 32'h0, 32'h8001_7FFF, 2, 0, 0, 0);
    repeat (3) @(posedge clk);
    chk("bus_queue_empty", bq.size(), 0);
    chk("res_queue_empty", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
